// File: rtl/shift_pkg.sv
// shift_pkg -- shared definitions for the universal shift register.
//
// Contents:
//   mode_e       : operation select encoding (hold / shift right /
//                  shift left / parallel load)
//   satInc()     : saturating increment helper used by the shift counter
//
// Optional feature macro used elsewhere in this slice: SHIFT_REG_ROTATE_EN
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Saturating +1. The value stays at limit once it has reached it.
  function automatic logic [31:0] satInc(input logic [31:0] value,
                                         input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/shift_cnt.sv
// shift_cnt -- saturating shift counter.
//
// Counts up by one on every cycle with inc_i high and stops at MAX.
// clear_i takes priority over inc_i; reset is synchronous, active-low.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   clear_i  : return the count to zero
//   inc_i    : count one shift
//   count_o  : current count, saturates at MAX
module shift_cnt
  import shift_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int MAX   = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise a saturating increment when asked.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = CNT_W'(satInc(32'(count_q), 32'(MAX)));
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ -- universal shift register with shift counter.
//
// Operations (only while iENABLE is high): hold, shift right (iSR enters
// the MSB), shift left (iSL enters the LSB), parallel load from iPR.
// Each shift bumps a counter that saturates at WIDTH; a load clears it.
// All outputs come straight from registered state.
//
// Ports:
//   iCLK     : clock, rising edge
//   iRST_n   : synchronous active-low reset (clears register and count)
//   iENABLE  : global enable, low holds everything
//   iMODE    : 00 hold, 01 shift right, 10 shift left, 11 load
//   iSR/iSL  : serial inputs for right / left shifts
//   iPR      : parallel load data
//   iROT     : (only with SHIFT_REG_ROTATE_EN) rotate instead of shift
//   oPR      : register contents
//   oSR/oSL  : LSB / MSB of the register
//   oCNT     : shifts since last load or reset, saturating at WIDTH
//   oDONE    : high while oCNT == WIDTH
//
// Optional feature macro: SHIFT_REG_ROTATE_EN
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iENABLE,
  input  logic [1:0]       iMODE,
  input  logic             iSR,
  input  logic             iSL,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             iROT,
`endif
  input  logic [WIDTH-1:0] iPR,
  output logic [WIDTH-1:0] oPR,
  output logic             oSR,
  output logic             oSL,
  output logic [CNT_W-1:0] oCNT,
  output logic             oDONE
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;
  logic             rightIn;
  logic             leftIn;
  logic             doShift;
  logic             doLoad;
  mode_e            mode;

  assign mode = mode_e'(iMODE);

  // Bits entering the register on a shift. With rotation enabled the bit
  // falling off the opposite end is recycled instead of the serial input.
`ifdef SHIFT_REG_ROTATE_EN
  assign rightIn = iROT ? reg_q[0]       : iSR;
  assign leftIn  = iROT ? reg_q[WIDTH-1] : iSL;
`else
  assign rightIn = iSR;
  assign leftIn  = iSL;
`endif

  // Next register value and the counter strobes for this cycle.
  always_comb begin
    reg_d   = reg_q;
    doShift = 1'b0;
    doLoad  = 1'b0;
    if (iENABLE) begin
      case (mode)
        MODE_SHR: begin
          reg_d   = {rightIn, reg_q[WIDTH-1:1]};
          doShift = 1'b1;
        end
        MODE_SHL: begin
          reg_d   = {reg_q[WIDTH-2:0], leftIn};
          doShift = 1'b1;
        end
        MODE_LOAD: begin
          reg_d  = iPR;
          doLoad = 1'b1;
        end
        default: begin
          reg_d = reg_q;
        end
      endcase
    end
  end

  // Data register; reset overrides enable and mode.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  shift_cnt #(
    .CNT_W (CNT_W),
    .MAX   (WIDTH)
  ) uCnt (
    .clk_i   (iCLK),
    .rst_ni  (iRST_n),
    .clear_i (doLoad),
    .inc_i   (doShift),
    .count_o (oCNT)
  );

  assign oPR   = reg_q;
  assign oSR   = reg_q[0];
  assign oSL   = reg_q[WIDTH-1];
  assign oDONE = (oCNT == CNT_W'(WIDTH));

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ -- self-checking bench for shift_reg_univ (WIDTH=7).
// Directed scenarios followed by random operations, all compared against
// an arithmetic reference model of the register and shift count.
// Optional feature macro: SHIFT_REG_ROTATE_EN
module tb_shift_reg_univ;

  localparam int W  = 7;
  localparam int CW = $clog2(W + 1);

  logic          iCLK = 1'b0;
  logic          iRST_n;
  logic          iENABLE;
  logic [1:0]    iMODE;
  logic          iSR;
  logic          iSL;
  logic          iROT;
  logic [W-1:0]  iPR;
  logic [W-1:0]  oPR;
  logic          oSR;
  logic          oSL;
  logic [CW-1:0] oCNT;
  logic          oDONE;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: register value as an integer and shift count.
  int mReg = 0;
  int mCnt = 0;

  always #5 iCLK = ~iCLK;

  shift_reg_univ #(.WIDTH(W)) dut (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iENABLE (iENABLE),
    .iMODE   (iMODE),
    .iSR     (iSR),
    .iSL     (iSL),
`ifdef SHIFT_REG_ROTATE_EN
    .iROT    (iROT),
`endif
    .iPR     (iPR),
    .oPR     (oPR),
    .oSR     (oSR),
    .oSL     (oSL),
    .oCNT    (oCNT),
    .oDONE   (oDONE)
  );

  // Model of one clock edge using the inputs currently applied.
  task automatic modelEdge();
    int full;
    int inBit;
    bit rot;
    full = (1 << W) - 1;
`ifdef SHIFT_REG_ROTATE_EN
    rot = iROT;
`else
    rot = 1'b0;
`endif
    if (!iRST_n) begin
      mReg = 0;
      mCnt = 0;
    end else if (iENABLE) begin
      if (iMODE == 2'd1) begin
        inBit = rot ? (mReg % 2) : int'(iSR);
        mReg  = (mReg / 2) + inBit * (1 << (W - 1));
        mCnt  = (mCnt < W) ? mCnt + 1 : W;
      end else if (iMODE == 2'd2) begin
        inBit = rot ? (mReg / (1 << (W - 1))) : int'(iSL);
        mReg  = ((mReg * 2) + inBit) & full;
        mCnt  = (mCnt < W) ? mCnt + 1 : W;
      end else if (iMODE == 2'd3) begin
        mReg = int'(iPR);
        mCnt = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst_n, input bit en,
                               input logic [1:0] mode, input bit sr,
                               input bit sl, input logic [W-1:0] pr,
                               input bit rot);
    iRST_n  = rst_n;
    iENABLE = en;
    iMODE   = mode;
    iSR     = sr;
    iSL     = sl;
    iPR     = pr;
    iROT    = rot;
    @(posedge iCLK);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [W-1:0]  ePR;
    logic [CW-1:0] eCNT;
    ePR  = W'(mReg);
    eCNT = CW'(mCnt);
    vectors++;
    assert (oPR === ePR) else begin
      miscompares++;
      $error("[TB] FAIL %s oPR observed=%h expected=%h", tag, oPR, ePR);
    end
    vectors++;
    assert (oCNT === eCNT) else begin
      miscompares++;
      $error("[TB] FAIL %s oCNT observed=%0d expected=%0d", tag, oCNT, eCNT);
    end
    vectors++;
    assert (oDONE === (mCnt == W)) else begin
      miscompares++;
      $error("[TB] FAIL %s oDONE observed=%b expected=%b", tag, oDONE, (mCnt == W));
    end
    vectors++;
    assert (oSR === ePR[0]) else begin
      miscompares++;
      $error("[TB] FAIL %s oSR observed=%b expected=%b", tag, oSR, ePR[0]);
    end
    vectors++;
    assert (oSL === ePR[W-1]) else begin
      miscompares++;
      $error("[TB] FAIL %s oSL observed=%b expected=%b", tag, oSL, ePR[W-1]);
    end
  endtask

  // Comparison against a fixed value taken from the worked examples.
  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    iRST_n = 1'b0; iENABLE = 1'b0; iMODE = 2'd0;
    iSR = 1'b0; iSL = 1'b0; iPR = '0; iROT = 1'b0;

    // Reset, with enable and load active to show reset dominates.
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 7'h7F, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 7'h7F, 1'b0);
    checkOutput("reset");
    checkValue("reset_pr", 32'(oPR), 32'h0);

    // Load 0x55.
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 7'h55, 1'b0);
    checkOutput("load55");
    checkValue("load55_pr", 32'(oPR), 32'h55);
    checkValue("load55_srsl", {30'd0, oSL, oSR}, 32'h3);

    // From zero, seven right shifts with iSR=1, then an eighth.
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 7'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 7'h00, 1'b0);
      checkOutput($sformatf("shr%0d", i + 1));
    end
    checkValue("shr7_pr", 32'(oPR), 32'h7F);
    checkValue("shr7_done", {31'd0, oDONE}, 32'h1);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 7'h00, 1'b0);
    checkOutput("shr8");
    checkValue("shr8_cnt", 32'(oCNT), 32'd7);

    // Load 0x01, three left shifts with iSL=0, then five disabled cycles.
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 7'h01, 1'b0);
    checkValue("load01_done", {31'd0, oDONE}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 7'h00, 1'b0);
      checkOutput($sformatf("shl%0d", i + 1));
    end
    checkValue("shl3_pr", 32'(oPR), 32'h08);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 2'(i % 3 + 1), 1'b1, 1'b1, 7'h7F, 1'b0);
      checkOutput($sformatf("disabled%0d", i));
    end
    checkValue("disabled_cnt", 32'(oCNT), 32'd3);

    // Mixed directions both count; then reset at count 4 with load requested.
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 7'h2A, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 7'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 7'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 7'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 7'h00, 1'b0);
    checkOutput("mixed4");
    checkValue("mixed4_cnt", 32'(oCNT), 32'd4);
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 7'h33, 1'b0);
    checkOutput("midreset");
    checkValue("midreset_pr", 32'(oPR), 32'h0);
    checkValue("midreset_cnt", 32'(oCNT), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 7'h00, 1'b0);
    checkOutput("postreset");
    checkValue("postreset_pr", 32'(oPR), 32'h01);

`ifdef SHIFT_REG_ROTATE_EN
    // Rotate right seven times from 0x01.
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 7'h01, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 7'h00, 1'b1);
    checkValue("rot1_pr", 32'(oPR), 32'h40);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 7'h00, 1'b1);
    end
    checkOutput("rot7");
    checkValue("rot7_pr", 32'(oPR), 32'h01);
    checkValue("rot7_done", {31'd0, oDONE}, 32'h1);
`endif

    // Random operations, occasional reset.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 24) != 0),
                    ($urandom_range(0, 4) != 0),
                    2'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom),
                    W'($urandom), 1'($urandom));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
